barcode_entry_controller: RTL

BARCODE_ENTRY_CONTROLLER -- requirements
Module: barcode_entry_controller

---
 rtl/barcode_pkg.sv | 25 ++
 rtl/barcode_lookup.sv | 31 +++
 rtl/barcode_entry_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/barcode_pkg.sv
// Shared definitions for the barcode entry block: FSM state encoding,
// product barcode table and entry constants.
package barcode_pkg;

    localparam int PRODUCT_COUNT = 12;
    localparam int BARCODE_W     = 16;

    localparam logic [3:0] MAX_BCD    = 4'd9;
    localparam logic [2:0] FULL_COUNT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,   // no digits held
        ST_ENTRY    = 2'd1,   // 1..3 digits held
        ST_COMPLETE = 2'd2    // 4 digits held
    } entry_state_t;

    // Known product barcodes, four BCD digits each, first digit in [15:12].
    // The position in this table is the product ID.
    localparam logic [BARCODE_W-1:0] PRODUCT_TABLE [PRODUCT_COUNT] = '{
        16'h0123, 16'h1111, 16'h2468, 16'h1357,
        16'h9876, 16'h5555, 16'h4321, 16'h8080,
        16'h7007, 16'h3141, 16'h2718, 16'h9999
    };

endpackage

// File: rtl/barcode_lookup.sv
// Combinational product table search. The lowest matching index wins;
// the ID reads 0 when nothing matches.
module barcode_lookup
    import barcode_pkg::*;
(
    input  logic [15:0] i_barcode,
    output logic        o_match,
    output logic [3:0]  o_id
);

    logic       w_hit;
    logic [3:0] w_id;

    // Linear search of the product table.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise
        // a path that skips the assignment infers a latch.
        w_hit = 1'b0;
        w_id  = 4'd0;
        for (int i = 0; i < PRODUCT_COUNT; i++) begin
            if (!w_hit && (i_barcode == PRODUCT_TABLE[i])) begin
                w_hit = 1'b1;
                w_id  = 4'(i);
            end
        end
    end

    assign o_match = w_hit;
    assign o_id    = w_id;

endmodule

// File: rtl/barcode_entry_controller.sv
// Four-digit barcode entry buffer with product lookup.
// Optional idle timeout enabled by defining BARCODE_ENTRY_TIMEOUT_EN.
// Strobe priority: RST > Clear > Consume > Backspace > DigitValid; a strobe
// that is not acceptable in the current state is treated as absent.
module barcode_entry_controller
    import barcode_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] DigitIn,
    input  logic       DigitValid,
    input  logic       Backspace,
    input  logic       Clear,
    input  logic       Consume,
    output logic [3:0] Barcode_Digit_3,
    output logic [3:0] Barcode_Digit_2,
    output logic [3:0] Barcode_Digit_1,
    output logic [3:0] Barcode_Digit_0,
    output logic [2:0] NumOfBarcodeDigitsEntered,
    output logic       BarcodeCompleted,
    output logic       BarcodeMatch,
    output logic [3:0] BarcodeProductID,
    output logic       EntryTimeout
);

    entry_state_t    r_state;
    logic [3:0][3:0] r_digits;     // [3] is the first digit entered
    logic [2:0]      r_count;
    logic            r_completed;
    logic            r_match;
    logic [3:0]      r_id;

    entry_state_t    w_next_state;
    logic [3:0][3:0] w_next_digits;
    logic [2:0]      w_next_count;
    logic            w_accept;
    logic            w_timeout_due;
    logic            w_lookup_match;
    logic [3:0]      w_lookup_id;

    // Lookup runs on the next-cycle digits so match/ID register together
    // with the digit that completes the barcode.
    barcode_lookup u_lookup (
        .i_barcode (w_next_digits),
        .o_match   (w_lookup_match),
        .o_id      (w_lookup_id)
    );

    // Next-state, next-digit and next-count decode with strobe priority.
    always_comb begin
        w_next_state  = r_state;
        w_next_digits = r_digits;
        w_next_count  = r_count;
        w_accept      = 1'b0;

        if (Clear || (Consume && (r_state == ST_COMPLETE))) begin
            w_accept      = 1'b1;
            w_next_state  = ST_IDLE;
            w_next_digits = '0;
            w_next_count  = '0;
        end else if (Backspace && (r_count != 3'd0)) begin
            w_accept                                 = 1'b1;
            w_next_digits[2'(FULL_COUNT - r_count)]  = 4'd0;
            w_next_count                             = r_count - 3'd1;
            w_next_state = (r_count == 3'd1) ? ST_IDLE : ST_ENTRY;
        end else if (DigitValid && (DigitIn <= MAX_BCD) && (r_state != ST_COMPLETE)) begin
            w_accept                                 = 1'b1;
            w_next_digits[2'(3'd3 - r_count)]        = DigitIn;
            w_next_count                             = r_count + 3'd1;
            w_next_state = (r_count == 3'd3) ? ST_COMPLETE : ST_ENTRY;
        end else if (w_timeout_due) begin
            w_next_state  = ST_IDLE;
            w_next_digits = '0;
            w_next_count  = '0;
        end
    end

    // State and output registers; synchronous reset discards any entry.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (RST) begin
            r_state     <= ST_IDLE;
            r_digits    <= '0;
            r_count     <= '0;
            r_completed <= 1'b0;
            r_match     <= 1'b0;
            r_id        <= '0;
        end else begin
            r_state     <= w_next_state;
            r_digits    <= w_next_digits;
            r_count     <= w_next_count;
            r_completed <= (w_next_state == ST_COMPLETE);
            r_match     <= (w_next_state == ST_COMPLETE) && w_lookup_match;
            r_id        <= (w_next_state == ST_COMPLETE) ? w_lookup_id : 4'd0;
        end
    end

`ifdef BARCODE_ENTRY_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TIMER_W-1:0] r_timer;
    logic               r_entry_timeout;

    assign w_timeout_due = (r_state != ST_IDLE) &&
                           (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: runs while digits are held, restarts on accepted strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timer         <= '0;
            r_entry_timeout <= 1'b0;
        end else begin
            r_entry_timeout <= w_timeout_due && !w_accept;
            if (w_accept || (w_next_state == ST_IDLE)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign EntryTimeout = r_entry_timeout;
`else
    assign w_timeout_due = 1'b0;
    assign EntryTimeout  = 1'b0;
`endif

    assign Barcode_Digit_3           = r_digits[3];
    assign Barcode_Digit_2           = r_digits[2];
    assign Barcode_Digit_1           = r_digits[1];
    assign Barcode_Digit_0           = r_digits[0];
    assign NumOfBarcodeDigitsEntered = r_count;
    assign BarcodeCompleted          = r_completed;
    assign BarcodeMatch              = r_match;
    assign BarcodeProductID          = r_id;

endmodule
